// File: rtl/plat_collision_scan_pkg.sv
// Shared game constants and the scan FSM state encoding for the platform
// collision scanner.
package plat_collision_scan_pkg;

    localparam int PLATFORM_NUM_PER_BLOCK = 7;
    localparam int PHY_WIDTH              = 16;
    localparam int BLOCK_LEN_WIDTH        = 4;
    localparam int PLAT_UNIT              = 16;
    localparam int CHAR_W                 = 32;

    // Platform index / hit_idx width (up to 8 platforms per block).
    localparam int IDX_WIDTH              = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SNAP = 2'd1,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } scan_state_t;

endpackage

// File: rtl/plat_collision_scan_if.sv
// Request/result bundle of the platform collision scanner.
//
// Handshake: start is a single-cycle request that is only taken while busy
// is low; the scan then runs with busy high and ends with a one-cycle done
// pulse, during which (and until the next done) hit/hit_idx/land_y are the
// result. block_switch cancels a scan that has not yet reached DONE.
interface plat_collision_scan_if #(
    parameter int NUM = plat_collision_scan_pkg::PLATFORM_NUM_PER_BLOCK,
    parameter int PW  = plat_collision_scan_pkg::PHY_WIDTH,
    parameter int LW  = plat_collision_scan_pkg::BLOCK_LEN_WIDTH
) ();
    import plat_collision_scan_pkg::*;

    logic                  start;
    logic [PW-1:0]         char_x;
    logic [PW-1:0]         char_y_prev;
    logic [PW-1:0]         char_y_cur;
    logic [NUM*PW-1:0]     plat_relative_x;
    logic [NUM*PW-1:0]     plat_relative_y;
    logic [NUM*LW-1:0]     plat_len;
    logic                  block_switch;
    logic                  busy;
    logic                  done;
    logic                  hit;
    logic [IDX_WIDTH-1:0]  hit_idx;
    logic [PW-1:0]         land_y;
    scan_state_t           dbg_state;

    modport master (
        output start, char_x, char_y_prev, char_y_cur,
               plat_relative_x, plat_relative_y, plat_len, block_switch,
        input  busy, done, hit, hit_idx, land_y, dbg_state
    );

    modport slave (
        input  start, char_x, char_y_prev, char_y_cur,
               plat_relative_x, plat_relative_y, plat_len, block_switch,
        output busy, done, hit, hit_idx, land_y, dbg_state
    );

endinterface

// File: rtl/plat_collision_scan_hit_test.sv
// Combinational landing test of the character against one platform.
// Horizontal overlap and edge sums use one extra bit so nothing wraps
// near the top of the coordinate range.
module plat_hit_test #(
    parameter int PW        = 16,
    parameter int LW        = 4,
    parameter int PLAT_UNIT = 16,
    parameter int CHAR_W    = 32
) (
    input  logic [PW-1:0] i_char_x,
    input  logic [PW-1:0] i_y_prev,
    input  logic [PW-1:0] i_y_cur,
    input  logic [PW-1:0] i_px,
    input  logic [PW-1:0] i_py,
    input  logic [LW-1:0] i_len,
    output logic          o_hit
);
    logic [PW:0] w_char_right;
    logic [PW:0] w_len_px;
    logic [PW:0] w_plat_right;

    assign w_char_right = {1'b0, i_char_x} + (PW+1)'(CHAR_W);
    assign w_len_px     = (PW+1)'(i_len) * (PW+1)'(PLAT_UNIT);
    assign w_plat_right = {1'b0, i_px} + w_len_px;

    // A zero length marks an empty slot; a rising character never lands.
    assign o_hit = (i_len != '0)
                && (w_char_right > {1'b0, i_px})
                && ({1'b0, i_char_x} < w_plat_right)
                && (i_y_prev >= i_py)
                && (i_y_cur <= i_py)
                && (i_y_cur <= i_y_prev);

endmodule

// File: rtl/plat_collision_scan.sv
// Platform collision scanner: snapshots the character and the block's
// platforms, walks the platforms one per cycle and reports the highest
// platform the character's feet crossed this frame.
module plat_collision_scan #(
    parameter int PLATFORM_NUM_PER_BLOCK = plat_collision_scan_pkg::PLATFORM_NUM_PER_BLOCK,
    parameter int PHY_WIDTH              = plat_collision_scan_pkg::PHY_WIDTH,
    parameter int BLOCK_LEN_WIDTH        = plat_collision_scan_pkg::BLOCK_LEN_WIDTH,
    parameter int PLAT_UNIT              = plat_collision_scan_pkg::PLAT_UNIT,
    parameter int CHAR_W                 = plat_collision_scan_pkg::CHAR_W
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    plat_collision_scan_if.slave  bus
);
    import plat_collision_scan_pkg::*;

    localparam int N     = PLATFORM_NUM_PER_BLOCK;
    localparam int PW    = PHY_WIDTH;
    localparam int LW    = BLOCK_LEN_WIDTH;
    localparam int SLOTS = 2 ** IDX_WIDTH;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N - 1);

    scan_state_t            r_state;
    scan_state_t            w_next_state;
    logic                   w_busy;
    logic                   w_done;

    logic [PW-1:0]          r_char_x;
    logic [PW-1:0]          r_y_prev;
    logic [PW-1:0]          r_y_cur;
    logic [N*PW-1:0]        r_px;
    logic [N*PW-1:0]        r_py;
    logic [N*LW-1:0]        r_len;
    logic [IDX_WIDTH-1:0]   r_idx;

    logic                   r_best_hit;
    logic [IDX_WIDTH-1:0]   r_best_idx;
    logic [PW-1:0]          r_best_y;

    logic                   r_hit;
    logic [IDX_WIDTH-1:0]   r_hit_idx;
    logic [PW-1:0]          r_land_y;

    logic [PW-1:0]          w_px_slot  [SLOTS];
    logic [PW-1:0]          w_py_slot  [SLOTS];
    logic [LW-1:0]          w_len_slot [SLOTS];
    logic [PW-1:0]          w_cur_px;
    logic [PW-1:0]          w_cur_py;
    logic [LW-1:0]          w_cur_len;
    logic                   w_cur_hit;
    logic                   w_take;
    logic                   w_nxt_hit;
    logic [IDX_WIDTH-1:0]   w_nxt_idx;
    logic [PW-1:0]          w_nxt_y;
    logic                   w_last;

    // Unpack the snapshot into a power-of-two table so the counter can
    // index it directly; slots past the last platform read as empty.
    for (genvar g = 0; g < SLOTS; g++) begin : g_slot
        if (g < N) begin : g_real
            assign w_px_slot[g]  = r_px[g*PW +: PW];
            assign w_py_slot[g]  = r_py[g*PW +: PW];
            assign w_len_slot[g] = r_len[g*LW +: LW];
        end else begin : g_pad
            assign w_px_slot[g]  = '0;
            assign w_py_slot[g]  = '0;
            assign w_len_slot[g] = '0;
        end
    end

    assign w_cur_px  = w_px_slot[r_idx];
    assign w_cur_py  = w_py_slot[r_idx];
    assign w_cur_len = w_len_slot[r_idx];

    plat_hit_test #(
        .PW        (PW),
        .LW        (LW),
        .PLAT_UNIT (PLAT_UNIT),
        .CHAR_W    (CHAR_W)
    ) u_hit_test (
        .i_char_x (r_char_x),
        .i_y_prev (r_y_prev),
        .i_y_cur  (r_y_cur),
        .i_px     (w_cur_px),
        .i_py     (w_cur_py),
        .i_len    (w_cur_len),
        .o_hit    (w_cur_hit)
    );

    // Strictly-higher replaces the best so far; since the scan ascends,
    // equal heights keep the lower index.
    assign w_take    = w_cur_hit && (!r_best_hit || (w_cur_py > r_best_y));
    assign w_nxt_hit = r_best_hit | w_take;
    assign w_nxt_idx = w_take ? r_idx : r_best_idx;
    assign w_nxt_y   = w_take ? w_cur_py : r_best_y;
    assign w_last    = (r_idx == LAST_IDX);

    // Next-state and status decode of the scan FSM.
    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) w_next_state = ST_SNAP;
            end
            ST_SNAP: begin
                w_busy       = 1'b1;
                w_next_state = bus.block_switch ? ST_IDLE : ST_SCAN;
            end
            ST_SCAN: begin
                w_busy = 1'b1;
                if (bus.block_switch) w_next_state = ST_IDLE;
                else if (w_last)      w_next_state = ST_DONE;
            end
            ST_DONE: begin
                w_busy       = 1'b1;
                w_done       = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State register, input snapshot, running best and committed result.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state    <= ST_IDLE;
            r_char_x   <= '0;
            r_y_prev   <= '0;
            r_y_cur    <= '0;
            r_px       <= '0;
            r_py       <= '0;
            r_len      <= '0;
            r_idx      <= '0;
            r_best_hit <= 1'b0;
            r_best_idx <= '0;
            r_best_y   <= '0;
            r_hit      <= 1'b0;
            r_hit_idx  <= '0;
            r_land_y   <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_SNAP: begin
                    r_char_x   <= bus.char_x;
                    r_y_prev   <= bus.char_y_prev;
                    r_y_cur    <= bus.char_y_cur;
                    r_px       <= bus.plat_relative_x;
                    r_py       <= bus.plat_relative_y;
                    r_len      <= bus.plat_len;
                    r_idx      <= '0;
                    r_best_hit <= 1'b0;
                    r_best_idx <= '0;
                    r_best_y   <= '0;
                end
                ST_SCAN: begin
                    r_idx      <= w_last ? '0 : r_idx + IDX_WIDTH'(1);
                    r_best_hit <= w_nxt_hit;
                    r_best_idx <= w_nxt_idx;
                    r_best_y   <= w_nxt_y;
                    if (w_last && !bus.block_switch) begin
                        r_hit     <= w_nxt_hit;
                        r_hit_idx <= w_nxt_idx;
                        r_land_y  <= w_nxt_y;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.hit       = r_hit;
    assign bus.hit_idx   = r_hit_idx;
    assign bus.land_y    = r_land_y;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_plat_collision_scan.sv
// Bench for plat_collision_scan: directed landing scenarios, boundary
// cases, abort by block_switch and by reset, all checked against a
// plain-arithmetic landing model.
module tb_plat_collision_scan;
    import plat_collision_scan_pkg::*;

    localparam int NP = 7;
    localparam int PW = 16;
    localparam int LW = 4;
    localparam int EW = 1 + 3 + PW;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    plat_collision_scan_if #(.NUM(NP), .PW(PW), .LW(LW)) bus ();

    plat_collision_scan dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus)
    );

    // ---------------- bookkeeping ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [EW-1:0] exp_q[$];

    int t_px[NP];
    int t_py[NP];
    int t_len[NP];
    int t_cx, t_yp, t_yc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] pk(input int h, input int idx, input int y);
        logic [EW-1:0] v;
        v = {1'(h), 3'(idx), 16'(y)};
        return v;
    endfunction

    // ---------------- behavioural model ----------------
    // Highest platform whose top lies between last and this frame's feet,
    // horizontally overlapping the character; ties go to the lower index.
    function automatic logic [EW-1:0] model();
        int best_i = -1;
        int best_y = 0;
        if (t_yc > t_yp) return pk(0, 0, 0);
        for (int i = 0; i < NP; i++) begin
            if (t_len[i] == 0) continue;
            if ((t_cx + 32 > t_px[i]) && (t_cx < t_px[i] + t_len[i] * 16) &&
                (t_yp >= t_py[i]) && (t_yc <= t_py[i])) begin
                if (best_i < 0 || t_py[i] > best_y) begin
                    best_i = i;
                    best_y = t_py[i];
                end
            end
        end
        if (best_i < 0) return pk(0, 0, 0);
        return pk(1, best_i, best_y);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic clear_plats();
        for (int i = 0; i < NP; i++) begin
            t_px[i] = 0; t_py[i] = 0; t_len[i] = 0;
        end
    endtask

    task automatic set_plat(input int i, input int x, input int y, input int len);
        t_px[i] = x; t_py[i] = y; t_len[i] = len;
    endtask

    task automatic apply();
        bus.char_x      = PW'(t_cx);
        bus.char_y_prev = PW'(t_yp);
        bus.char_y_cur  = PW'(t_yc);
        for (int i = 0; i < NP; i++) begin
            bus.plat_relative_x[i*PW +: PW] = PW'(t_px[i]);
            bus.plat_relative_y[i*PW +: PW] = PW'(t_py[i]);
            bus.plat_len[i*LW +: LW]        = LW'(t_len[i]);
        end
    endtask

    // Full scan; optionally re-pulses start and scrambles the inputs at
    // poke_cycle (0 = never) to show both are ignored mid-scan.
    task automatic run_scan(input string tag, input int poke_cycle, output logic [EW-1:0] res);
        int lat = 0;
        bit found = 0;
        res = model();
        exp_q.push_back(res);
        apply();
        bus.start = 1'b1;
        for (int n = 1; n <= 20 && !found; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                bus.start = 1'b0;
                check({tag, "_busy_snap"}, 32'(bus.busy), 1);
            end
            if (poke_cycle != 0 && n == poke_cycle) begin
                bus.start       = 1'b1;
                bus.char_y_prev = PW'(t_py[0] + 20);
                bus.char_y_cur  = PW'(0);
            end
            if (poke_cycle != 0 && n == poke_cycle + 1) bus.start = 1'b0;
            if (bus.done) begin
                found = 1;
                lat   = n;
            end
        end
        check({tag, "_done_seen"}, 32'(found), 1);
        if (found) check({tag, "_latency"}, 32'(lat), 9);
        @(posedge clk); #1;
        check({tag, "_done_1cyc"}, 32'(bus.done), 0);
        check({tag, "_idle_after"}, 32'(bus.busy), 0);
    endtask

    // Watches for a window and reports any done pulse.
    task automatic expect_quiet(input string tag, input int cycles);
        bit saw = 0;
        for (int n = 0; n < cycles; n++) begin
            @(posedge clk); #1;
            if (bus.done) saw = 1;
        end
        check({tag, "_no_done"}, 32'(saw), 0);
    endtask

    // Starts a scan and kills it at at_cycle by block_switch or reset.
    task automatic abort_scan(input string tag, input int at_cycle, input bit use_reset);
        apply();
        bus.start = 1'b1;
        for (int n = 1; n <= at_cycle; n++) begin
            @(posedge clk); #1;
            if (n == 1) bus.start = 1'b0;
        end
        check({tag, "_busy_mid"}, 32'(bus.busy), 1);
        if (use_reset) rst_n = 1'b0;
        else           bus.block_switch = 1'b1;
        @(posedge clk); #1;
        check({tag, "_busy_after"}, 32'(bus.busy), 0);
        check({tag, "_done_after"}, 32'(bus.done), 0);
        if (use_reset) begin
            check({tag, "_hit_rst"},   32'(bus.hit), 0);
            check({tag, "_idx_rst"},   32'(bus.hit_idx), 0);
            check({tag, "_landy_rst"}, 32'(bus.land_y), 0);
        end
        rst_n            = 1'b1;
        bus.block_switch = 1'b0;
        expect_quiet(tag, 15);
    endtask

    // ---------------- scoreboard compare process ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rst_n && bus.done) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending scan");
            end else begin
                e = exp_q.pop_front();
                check("sb_hit", 32'(bus.hit), 32'(e[EW-1]));
                if (e[EW-1]) begin
                    check("sb_hit_idx", 32'(bus.hit_idx), 32'(e[PW +: 3]));
                    check("sb_land_y",  32'(bus.land_y),  32'(e[PW-1:0]));
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [EW-1:0] res;

        bus.start           = 1'b0;
        bus.block_switch    = 1'b0;
        bus.char_x          = '0;
        bus.char_y_prev     = '0;
        bus.char_y_cur      = '0;
        bus.plat_relative_x = '0;
        bus.plat_relative_y = '0;
        bus.plat_len        = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",  32'(bus.busy), 0);
        check("rst_done",  32'(bus.done), 0);
        check("rst_hit",   32'(bus.hit), 0);
        check("rst_idx",   32'(bus.hit_idx), 0);
        check("rst_landy", 32'(bus.land_y), 0);
        check("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic landing on platform 0.
        clear_plats();
        t_cx = 290; t_yp = 40; t_yc = 30;
        set_plat(0, 280, 35, 10);
        run_scan("s1", 0, res);
        check("s1_model", 32'(res), 32'(pk(1, 0, 35)));
        check("s1_hold_y", 32'(bus.land_y), 35);

        // Two candidates, the higher one wins.
        clear_plats();
        t_cx = 40; t_yp = 270; t_yc = 240;
        set_plat(3, 30, 250, 8);
        set_plat(5, 30, 260, 8);
        run_scan("s2", 0, res);
        check("s2_model", 32'(res), 32'(pk(1, 5, 260)));
        check("s2_hold_idx", 32'(bus.hit_idx), 5);

        // Horizontal edges: touching is not overlapping.
        clear_plats();
        t_yp = 20; t_yc = 5;
        set_plat(0, 32, 10, 2);
        t_cx = 0;  run_scan("s3a", 0, res); check("s3a_model", 32'(res), 32'(pk(0, 0, 0)));
        t_cx = 1;  run_scan("s3b", 0, res); check("s3b_model", 32'(res), 32'(pk(1, 0, 10)));
        t_cx = 63; run_scan("s3c", 0, res); check("s3c_model", 32'(res), 32'(pk(1, 0, 10)));
        t_cx = 64; run_scan("s3d", 0, res); check("s3d_model", 32'(res), 32'(pk(0, 0, 0)));

        // Equal heights pick the lower index; a zero-length slot never lands.
        clear_plats();
        t_cx = 110; t_yp = 250; t_yc = 150;
        set_plat(1, 100, 200, 4);
        set_plat(4, 100, 200, 4);
        set_plat(6, 100, 240, 0);
        run_scan("s4", 0, res);
        check("s4_model", 32'(res), 32'(pk(1, 1, 200)));

        // Feet exactly on the platform top in both frames.
        clear_plats();
        t_cx = 10; t_yp = 100; t_yc = 100;
        set_plat(2, 0, 100, 3);
        run_scan("s5", 0, res);
        check("s5_model", 32'(res), 32'(pk(1, 2, 100)));

        // Right edge past the 16-bit range must not wrap.
        clear_plats();
        t_cx = 65535; t_yp = 60; t_yc = 40;
        set_plat(0, 65530, 50, 15);
        run_scan("s6", 0, res);
        check("s6_model", 32'(res), 32'(pk(1, 0, 50)));

        // Rising character; start and input changes mid-scan are ignored.
        clear_plats();
        t_cx = 290; t_yp = 30; t_yc = 40;
        set_plat(0, 280, 35, 10);
        run_scan("s7", 3, res);
        check("s7_model", 32'(res), 32'(pk(0, 0, 0)));
        expect_quiet("s7_extra_start", 12);

        // block_switch in cycle 4, then a clean scan.
        clear_plats();
        t_cx = 290; t_yp = 40; t_yc = 30;
        set_plat(0, 280, 35, 10);
        abort_scan("s8", 4, 1'b0);
        run_scan("s8b", 0, res);
        check("s8b_model", 32'(res), 32'(pk(1, 0, 35)));

        // Reset in cycle 5 clears the previous hit result.
        abort_scan("s9", 5, 1'b1);

        check("queue_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before limit");
        $fatal(1, "time limit");
    end

endmodule
